// File: rtl/counter_monitor.sv
// Observes an up-counter's enable and output, predicts each next value and flags discontinuities.
// Latency: every output is registered, so an event sampled on edge k is visible just after edge k.
// Backpressure: none. This is a passive observer that never stalls the counter.
module counter_monitor #(
    parameter int WIDTH      = 4,
    parameter int STAT_WIDTH = 8,
    parameter int MAX_MISS   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      counter_in,
    input  logic                  clear,
    output logic                  error,
    output logic                  reset_err,
    output logic                  fault,
    output logic [STAT_WIDTH-1:0] error_count,
    output logic                  wrap_pulse,
    output logic [STAT_WIDTH-1:0] wrap_count,
    output logic                  first_err_valid,
    output logic [WIDTH-1:0]      first_err_expected,
    output logic [WIDTH-1:0]      first_err_actual
);

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    localparam logic [STAT_WIDTH-1:0] STAT_MAX   = '1;
    localparam logic [3:0]            MISS_LIMIT = 4'(MAX_MISS);

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        exp_val, exp_nxt;
    logic [3:0]              miss, miss_nxt;
    logic                    error_nxt, reset_err_nxt, fault_nxt, wrap_nxt;
    logic [STAT_WIDTH-1:0]   ecnt_nxt, wcnt_nxt;
    logic                    fev_nxt;
    logic [WIDTH-1:0]        fee_nxt, fea_nxt;
    logic [WIDTH-1:0]        nxt;
    logic                    log_err;

    always_comb begin
        state_nxt     = state;
        exp_nxt       = exp_val;
        miss_nxt      = miss;
        error_nxt     = 1'b0;
        wrap_nxt      = 1'b0;
        reset_err_nxt = reset_err;
        fault_nxt     = fault;
        ecnt_nxt      = error_count;
        wcnt_nxt      = wrap_count;
        fev_nxt       = first_err_valid;
        fee_nxt       = first_err_expected;
        fea_nxt       = first_err_actual;
        log_err       = 1'b0;
        nxt           = counter_in + WIDTH'(enable);

        case (state)
            SYNC: begin
                if (counter_in != '0) begin
                    log_err       = 1'b1;
                    reset_err_nxt = 1'b1;
                end
                exp_nxt   = nxt;
                state_nxt = TRACK;
            end
            TRACK: begin
                if (counter_in != exp_val) begin
                    // Resync to the observed value so one jump is counted once.
                    log_err  = 1'b1;
                    exp_nxt  = nxt;
                    miss_nxt = miss + 4'd1;
                    if (miss_nxt == MISS_LIMIT) begin
                        fault_nxt = 1'b1;
                        state_nxt = FAULT;
                    end
                end else begin
                    exp_nxt  = exp_val + WIDTH'(enable);
                    miss_nxt = 4'd0;
                    if (enable && (&counter_in)) begin
                        wrap_nxt = 1'b1;
                        if (wrap_count != STAT_MAX) wcnt_nxt = wrap_count + 1'b1;
                    end
                end
            end
            FAULT: begin
                exp_nxt = nxt;
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase

        if (log_err) begin
            error_nxt = 1'b1;
            if (error_count != STAT_MAX) ecnt_nxt = error_count + 1'b1;
            if (!first_err_valid) begin
                fev_nxt = 1'b1;
                fee_nxt = exp_val;
                fea_nxt = counter_in;
            end
        end

        // Clear beats the increment and capture, but the error pulse still goes out.
        if (clear) begin
            ecnt_nxt      = '0;
            wcnt_nxt      = '0;
            fev_nxt       = 1'b0;
            fee_nxt       = '0;
            fea_nxt       = '0;
            reset_err_nxt = 1'b0;
            fault_nxt     = 1'b0;
            miss_nxt      = 4'd0;
            if (state_nxt == FAULT) state_nxt = TRACK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= SYNC;
            exp_val            <= '0;
            miss               <= 4'd0;
            error              <= 1'b0;
            reset_err          <= 1'b0;
            fault              <= 1'b0;
            error_count        <= '0;
            wrap_pulse         <= 1'b0;
            wrap_count         <= '0;
            first_err_valid    <= 1'b0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
        end else begin
            state              <= state_nxt;
            exp_val            <= exp_nxt;
            miss               <= miss_nxt;
            error              <= error_nxt;
            reset_err          <= reset_err_nxt;
            fault              <= fault_nxt;
            error_count        <= ecnt_nxt;
            wrap_pulse         <= wrap_nxt;
            wrap_count         <= wcnt_nxt;
            first_err_valid    <= fev_nxt;
            first_err_expected <= fee_nxt;
            first_err_actual   <= fea_nxt;
        end
    end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Synthesizable checker sitting on the consuming end of the up-counter interface: it observes the same clock, reset and enable that drive the counter, plus the counter's count output. From these it predicts the next count, flags every discontinuity, and keeps error, wrap and fault statistics. It is the receiving side of the counter's output bus, for on-chip self-check and for bench scoreboarding.

## Interface
- WIDTH, 4, width of the observed count.
- STAT_WIDTH, 8, width of the error_count and wrap_count statistics counters.
- MAX_MISS, 3, number of consecutive mismatches that forces the FAULT state (range 1 to 15).
- clock  in  1  rising-edge clock shared with the observed counter.
- reset  in  1  synchronous, active-high reset; the same reset as the observed counter.
- enable  in  1  the counter's count enable, sampled on the same edge as the counter samples it.
- counter_in  in  WIDTH  the counter's registered output.
- clear  in  1  synchronous statistics clear and fault release.
- error  out  1  one-cycle pulse: the mismatch detected on the previous edge.
- reset_err  out  1  sticky: counter_in was not 0 on the first edge after reset.
- fault  out  1  sticky: MAX_MISS consecutive mismatches occurred.
- error_count  out  STAT_WIDTH  saturating count of mismatches.
- wrap_pulse  out  1  one-cycle pulse: a correct all-ones to 0 wrap was committed.
- wrap_count  out  STAT_WIDTH  saturating count of wraps.
- first_err_valid  out  1  the first_err_* fields hold a captured mismatch.
- first_err_expected  out  WIDTH  predicted value at the first mismatch.
- first_err_actual  out  WIDTH  observed value at the first mismatch.

## Operation
- Registers: `exp` (WIDTH), `miss` (4-bit), `state` in {SYNC, TRACK, FAULT}.
- Mismatch is defined as `counter_in != exp`. `nxt` is defined as `counter_in + enable`, taken mod 2^WIDTH.
- Reset (highest priority):
  - Clears all outputs, `exp` and `miss` to 0.
  - Sets `state` to SYNC.
  - No comparison is made on reset edges.
- SYNC: evaluated on the first edge with reset low.
  - Compare counter_in with 0.
  - On mismatch: set reset_err, pulse error, increment error_count, and capture first_err_* if not already valid.
  - Always: `exp <= nxt`, go to TRACK.
- TRACK, on a match:
  - `exp <= exp + enable`, `miss <= 0`.
  - If enable=1 and counter_in is all ones: pulse wrap_pulse and increment wrap_count.
- TRACK, on a mismatch:
  - Pulse error, increment error_count, and capture first_err_* if first_err_valid=0.
  - Resynchronise with `exp <= nxt`, so each discontinuity is counted once.
  - Increment `miss`. If the new value equals MAX_MISS, set fault and go to FAULT.
- FAULT:
  - No comparison; error, error_count and wrap statistics are frozen.
  - `exp <= nxt` every edge, so the prediction keeps tracking.
  - The state is left only by clear or reset.
- clear (reset low):
  - Zeroes error_count, wrap_count, first_err_*, reset_err, fault and `miss`.
  - FAULT goes to TRACK with `exp <= nxt`.
  - Comparison in SYNC and TRACK still occurs on the clear edge. The error pulse is emitted, but counters end at 0 and no first-error capture happens: clear wins over the increment and the capture.
- Statistics saturate at 2^STAT_WIDTH-1 and never wrap.
- enable=0 with a constant counter_in is a match; this is a hold, not an error.

## Timing
- All outputs are registered. An event sampled at edge k is visible after edge k and held until edge k+1.
- error and wrap_pulse are high for exactly one cycle per event.
- Back-to-back mismatches give consecutive error pulses.
- Prediction model: counter_in at edge k must equal the value at edge k-1 plus the enable seen at edge k-1, or 0 if reset was high at edge k-1.
- Reset asserted mid-run:
  - Takes effect at that edge.
  - The sticky flags, statistics and first_err capture are lost.
  - The reset edge is never checked.
- Wrap: all ones plus 1 gives 0. This is a match, not an error.

## Test plan
- Reset for 2 cycles, then enable=1 for 10 cycles with a correct counter (0..10): error never pulses, error_count=0, reset_err=0, wrap_count=0.
- Correct counter enabled for 20 cycles from 0: exactly one wrap_pulse, on the edge sampling counter_in=15 with enable=1; wrap_count=1; error_count=0.
- Inject a jump 5->9 with enable=1:
  - error pulses once, error_count=1, first_err_expected=6, first_err_actual=9, first_err_valid=1.
  - Following values 10, 11 produce no error.
  - A second later jump leaves first_err_* unchanged.
- Drive counter_in=3 on the first edge after reset: reset_err=1, error_count=1, and the state proceeds to TRACK with exp=3+enable.
- MAX_MISS=3, counter_in random-jumping for 3 edges: three error pulses, fault=1 after the third.
  - Further jumps produce no pulses and error_count stays 3.
  - clear for one cycle drops fault and zeroes the statistics; correct counting afterwards gives no errors.
- STAT_WIDTH=2, 5 injected isolated mismatches: error_count saturates at 3. clear coinciding with a mismatch: error pulses, error_count=0, first_err_valid=0.
